// File: rtl/tage_u_aging_ctrl.sv
// tage_u_aging_ctrl: periodic graceful reset of TAGE u counters with
// write-port arbitration between the update path and the aging sweep.
module tage_u_aging_ctrl #(
   parameter int IDX_WIDTH    = 9,
   parameter int PERIOD_LOG2  = 18,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 retire_i,
   input  logic                 start_i,
   input  logic                 upd_req_i,
   output logic                 upd_gnt_o,
   output logic                 sweep_valid_o,
   output logic [IDX_WIDTH-1:0] sweep_idx_o,
   output logic                 sweep_bit_o,
   output logic                 busy_o,
   output logic                 done_o
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
   state_t                 state_q, state_d;
   logic [PERIOD_LOG2-1:0] period_q;
   logic [SW-1:0]          starve_q;
   logic                   pending_q, force_w, trig, enter;
   // A wrap and a start in the same cycle collapse into one trigger.
   assign trig          = start_i | (retire_i & (&period_q));
   assign busy_o        = state_q == SWEEP;
   assign done_o        = state_q == DONE;
   assign enter         = (state_q == IDLE) & pending_q;
   assign force_w       = busy_o & (starve_q == SW'(STARVE_LIMIT));
   assign upd_gnt_o     = upd_req_i & ~force_w;
   assign sweep_valid_o = busy_o & (~upd_req_i | force_w);
   always_comb
      state_d = enter ? SWEEP :
                (sweep_valid_o & (&sweep_idx_o)) ? DONE :
                done_o ? IDLE : state_q;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q     <= IDLE;
         period_q    <= '0;
         pending_q   <= 1'b0;
         sweep_idx_o <= '0;
         sweep_bit_o <= 1'b1;
         starve_q    <= '0;
      end else begin
         state_q     <= state_d;
         period_q    <= period_q + PERIOD_LOG2'(retire_i);
         pending_q   <= ~enter & (pending_q | trig);
         sweep_idx_o <= enter ? '0 : sweep_valid_o ? sweep_idx_o + 1'b1 : sweep_idx_o;
         sweep_bit_o <= sweep_bit_o ^ done_o;
         starve_q    <= (busy_o & ~sweep_valid_o) ? starve_q + 1'b1 : '0;
      end
endmodule

// File: tb/tb_tage_u_aging_ctrl.sv
// tb_tage_u_aging_ctrl: directed stimulus checked every cycle against a
// sweep-level model, plus hand-computed expectations from the test plan.
module tb_tage_u_aging_ctrl;
   localparam int IW = 3, PL = 4, SL = 2;
   localparam int NIDX = 1 << IW, NPER = 1 << PL;
   logic clk_i = 0, rst_ni = 0, retire_i = 0, start_i = 0, upd_req_i = 0;
   logic upd_gnt_o, sweep_valid_o, sweep_bit_o, busy_o, done_o;
   logic [IW-1:0] sweep_idx_o;
   int n_vec = 0, n_err = 0, n_done = 0;
   int m_cnt, m_left, m_blk;
   bit m_pend, m_done, m_bit;

   tage_u_aging_ctrl #(.IDX_WIDTH(IW), .PERIOD_LOG2(PL), .STARVE_LIMIT(SL)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .retire_i(retire_i), .start_i(start_i),
      .upd_req_i(upd_req_i), .upd_gnt_o(upd_gnt_o), .sweep_valid_o(sweep_valid_o),
      .sweep_idx_o(sweep_idx_o), .sweep_bit_o(sweep_bit_o), .busy_o(busy_o), .done_o(done_o));

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a sweep is "entries left to clear"; the starvation rule is a run
   // length of blocked cycles; the DONE cycle is a flag between sweeps.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_cnt <= 0; m_pend <= 0; m_left <= 0; m_blk <= 0; m_done <= 0; m_bit <= 1;
      end else begin
         bit trig, bz, frc, val;
         trig = start_i || (retire_i && m_cnt == NPER - 1);
         bz   = m_left > 0;
         frc  = bz && m_blk == SL;
         val  = bz && (!upd_req_i || frc);
         m_cnt  <= (m_cnt + int'(retire_i)) % NPER;
         m_done <= val && m_left == 1;
         m_blk  <= (bz && !val) ? m_blk + 1 : 0;
         if (m_done) m_bit <= !m_bit;
         if (!bz && !m_done && m_pend) begin
            m_left <= NIDX;
            m_pend <= 0;
         end else begin
            if (val) m_left <= m_left - 1;
            m_pend <= m_pend || trig;
         end
      end
   end

   always @(negedge clk_i) begin
      bit bz, frc;
      bz  = m_left > 0;
      frc = bz && m_blk == SL;
      chk("busy", int'(busy_o), int'(bz));
      chk("gnt", int'(upd_gnt_o), int'(upd_req_i && !frc));
      chk("valid", int'(sweep_valid_o), int'(bz && (!upd_req_i || frc)));
      chk("idx", int'(sweep_idx_o), bz ? NIDX - m_left : 0);
      chk("bit", int'(sweep_bit_o), int'(m_bit));
      chk("done", int'(done_o), int'(m_done));
      if (done_o) n_done++;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic pulse_start();
      start_i = 1; tick(); start_i = 0;
   endtask

   task automatic wait_busy();
      int k = 0;
      while (!busy_o && k < 50) begin tick(); k++; end
      chk("busy_timeout", int'(busy_o), 1);
   endtask

   task automatic wait_done();
      int k = 0;
      while (!done_o && k < 100) begin tick(); k++; end
      chk("done_timeout", int'(done_o), 1);
   endtask

   initial begin
      int d0, cyc, cv, cg, k;
      repeat (2) tick();
      upd_req_i = 1;
      #1;
      chk("rst_gnt", int'(upd_gnt_o), 1);
      chk("rst_valid", int'(sweep_valid_o), 0);
      chk("rst_idx", int'(sweep_idx_o), 0);
      chk("rst_bit", int'(sweep_bit_o), 1);
      chk("rst_busy", int'(busy_o), 0);
      upd_req_i = 0;
      tick(); rst_ni = 1; tick();
      // first period: 16 retires, MSB sweep
      retire_i = 1; repeat (NPER) tick(); retire_i = 0;
      chk("lat_t1_busy", int'(busy_o), 0);
      tick();
      chk("lat_t2_busy", int'(busy_o), 1);
      for (int i = 0; i < NIDX; i++) begin
         chk("p1_valid", int'(sweep_valid_o), 1);
         chk("p1_idx", int'(sweep_idx_o), i);
         chk("p1_bit", int'(sweep_bit_o), 1);
         tick();
      end
      chk("p1_done", int'(done_o), 1);
      tick();
      chk("p1_done_once", int'(done_o), 0);
      chk("p1_bit_after", int'(sweep_bit_o), 0);
      // second period: LSB sweep
      retire_i = 1; repeat (NPER) tick(); retire_i = 0;
      wait_busy();
      chk("p2_bit", int'(sweep_bit_o), 0);
      wait_done(); tick();
      chk("p2_bit_after", int'(sweep_bit_o), 1);
      // starvation: update path hammers the port for the whole sweep
      upd_req_i = 1;
      pulse_start();
      wait_busy();
      cyc = 0; cv = 0; cg = 0;
      while (busy_o && cyc < 100) begin
         if (sweep_valid_o) cv++;
         if (upd_gnt_o) cg++;
         cyc++;
         tick();
      end
      chk("starve_cycles", cyc, 24);
      chk("starve_writes", cv, 8);
      chk("starve_grants", cg, 16);
      upd_req_i = 0;
      tick(); tick();
      // two starts during a sweep yield exactly one follow-up sweep
      d0 = n_done;
      pulse_start();
      wait_busy();
      tick(); tick();
      pulse_start();
      tick();
      pulse_start();
      wait_done(); tick();
      chk("gap_idle", int'(busy_o), 0);
      tick();
      chk("gap_busy", int'(busy_o), 1);
      wait_done();
      repeat (20) tick();
      chk("two_sweeps", n_done - d0, 2);
      // reset mid-sweep at idx 5
      pulse_start();
      wait_busy();
      k = 0;
      while (sweep_idx_o != 5 && k < 20) begin tick(); k++; end
      chk("at_idx5", int'(sweep_idx_o), 5);
      #2 rst_ni = 0; upd_req_i = 1;
      #1;
      chk("arst_valid", int'(sweep_valid_o), 0);
      chk("arst_gnt", int'(upd_gnt_o), 1);
      chk("arst_idx", int'(sweep_idx_o), 0);
      chk("arst_bit", int'(sweep_bit_o), 1);
      chk("arst_busy", int'(busy_o), 0);
      chk("arst_done", int'(done_o), 0);
      repeat (3) tick();
      rst_ni = 1; upd_req_i = 0;
      cv = 0;
      repeat (20) begin if (sweep_valid_o || busy_o) cv++; tick(); end
      chk("no_resume", cv, 0);
      // wrap and start in the same cycle
      d0 = n_done;
      retire_i = 1; repeat (NPER - 1) tick();
      start_i = 1; tick(); start_i = 0; retire_i = 0;
      wait_busy();
      chk("wrap_start_bit", int'(sweep_bit_o), 1);
      wait_done();
      repeat (30) tick();
      chk("wrap_start_once", n_done - d0, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
